// File: rtl/rx_frame_guard.sv
// Frame-buffering guard between the UART byte stream and the command decoder.
// A frame [addr][len][payload] becomes visible downstream only once complete and valid.
`timescale 1ns/1ps
module rx_frame_guard #(
   parameter int unsigned DEPTH       = 64,
   parameter int unsigned TIMEOUT_CYC = 100000,
   parameter int unsigned N_SRC       = 25,
   parameter int unsigned CNT_W       = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [7:0]       out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CNT_W-1:0] err_tmo_cnt,
   output logic [CNT_W-1:0] err_addr_cnt,
   output logic [CNT_W-1:0] err_ovf_cnt,
   output logic             frame_drop
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;
   localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [1:0] {S_ADDR, S_LEN, S_PAY} state_t;

   logic [7:0]       r_mem [DEPTH];
   logic [PW-1:0]    r_wr_ptr, r_commit_ptr, r_rd_ptr;
   state_t           r_state;
   logic             r_bad_addr, r_ovf;
   logic [7:0]       r_remaining;
   logic [TW-1:0]    r_tmo;
   logic             r_in_ready, r_out_valid, r_frame_drop;
   logic [7:0]       r_out_data;
   logic [CNT_W-1:0] r_tmo_cnt, r_addr_cnt, r_ovf_cnt;

   logic             w_accept, w_tmo_fire, w_bad_in, w_ovf_in, w_full;
   logic             w_try_store, w_store, w_ovf_hit, w_ovf_next;
   logic             w_frame_end, w_reject, w_load;
   state_t           w_state;
   logic [PW-1:0]    w_wr_base, w_wr_after;

   // A timeout and a new byte in the same cycle: the frame is aborted first and the
   // byte is processed as an address byte against the rewound write pointer.
   always_comb begin
      w_accept    = in_valid & r_in_ready;
      w_tmo_fire  = (r_state != S_ADDR) && (r_tmo == TW'(TIMEOUT_CYC));
      w_state     = w_tmo_fire ? S_ADDR : r_state;
      w_wr_base   = w_tmo_fire ? r_commit_ptr : r_wr_ptr;
      w_bad_in    = (w_state == S_ADDR) ? (32'(in_data) >= N_SRC) : r_bad_addr;
      w_ovf_in    = (w_state == S_ADDR) ? 1'b0 : r_ovf;
      w_full      = (w_wr_base - r_rd_ptr) == PW'(DEPTH);
      w_try_store = w_accept & ~w_bad_in & ~w_ovf_in;
      w_store     = w_try_store & ~w_full;
      w_ovf_hit   = w_try_store & w_full;
      w_ovf_next  = w_ovf_in | w_ovf_hit;
      if (w_ovf_hit)    w_wr_after = r_commit_ptr;
      else if (w_store) w_wr_after = w_wr_base + 1'b1;
      else              w_wr_after = w_wr_base;
      w_frame_end = w_accept & (((w_state == S_LEN) && (in_data == 8'd0)) ||
                                ((w_state == S_PAY) && (r_remaining == 8'd1)));
      w_reject    = w_frame_end & (w_bad_in | w_ovf_next);
      w_load      = (~r_out_valid | out_ready) & (r_rd_ptr != r_commit_ptr);
   end

   always_ff @(posedge clk) begin
      if (w_store) r_mem[w_wr_base[AW-1:0]] <= in_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_in_ready   <= 1'b0;
         r_state      <= S_ADDR;
         r_wr_ptr     <= '0;
         r_commit_ptr <= '0;
         r_bad_addr   <= 1'b0;
         r_ovf        <= 1'b0;
         r_remaining  <= '0;
         r_tmo        <= '0;
         r_frame_drop <= 1'b0;
         r_tmo_cnt    <= '0;
         r_addr_cnt   <= '0;
         r_ovf_cnt    <= '0;
      end else begin
         r_in_ready   <= 1'b1;
         r_frame_drop <= 1'b0;
         r_wr_ptr     <= w_wr_after;
         if (w_accept || (w_state == S_ADDR)) r_tmo <= '0;
         else                                 r_tmo <= r_tmo + 1'b1;

         if (w_tmo_fire) begin
            r_frame_drop <= 1'b1;
            if (r_tmo_cnt != '1) r_tmo_cnt <= r_tmo_cnt + 1'b1;
         end

         if (w_accept) begin
            case (w_state)
               S_ADDR: begin
                  r_state    <= S_LEN;
                  r_bad_addr <= w_bad_in;
                  r_ovf      <= w_ovf_next;
               end
               S_LEN: begin
                  r_remaining <= in_data;
                  r_ovf       <= w_ovf_next;
                  r_state     <= S_PAY;
               end
               default: begin
                  r_remaining <= r_remaining - 8'd1;
                  r_ovf       <= w_ovf_next;
               end
            endcase
         end else if (w_tmo_fire) begin
            r_state    <= S_ADDR;
            r_bad_addr <= 1'b0;
            r_ovf      <= 1'b0;
         end

         if (w_frame_end) begin
            r_state    <= S_ADDR;
            r_bad_addr <= 1'b0;
            r_ovf      <= 1'b0;
            if (w_reject) begin
               r_wr_ptr     <= r_commit_ptr;
               r_frame_drop <= 1'b1;
               if (w_bad_in) begin
                  if (r_addr_cnt != '1) r_addr_cnt <= r_addr_cnt + 1'b1;
               end else begin
                  if (r_ovf_cnt != '1) r_ovf_cnt <= r_ovf_cnt + 1'b1;
               end
            end else begin
               r_commit_ptr <= w_wr_after;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rd_ptr    <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
      end else if (w_load) begin
         r_out_data  <= r_mem[r_rd_ptr[AW-1:0]];
         r_out_valid <= 1'b1;
         r_rd_ptr    <= r_rd_ptr + 1'b1;
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign in_ready     = r_in_ready;
   assign out_data     = r_out_data;
   assign out_valid    = r_out_valid;
   assign err_tmo_cnt  = r_tmo_cnt;
   assign err_addr_cnt = r_addr_cnt;
   assign err_ovf_cnt  = r_ovf_cnt;
   assign frame_drop   = r_frame_drop;

endmodule

// File: tb/tb_rx_frame_guard.sv
// Scoreboard bench for rx_frame_guard: expected bytes are queued as good frames are sent
// and popped by an output monitor; each scenario task checks its own counters and timing.
`timescale 1ns/1ps
module tb_rx_frame_guard;
   localparam int unsigned DEPTH = 16;
   localparam int unsigned TMO   = 200;
   localparam int unsigned NSRC  = 25;
   localparam int unsigned CW    = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic [7:0]    in_data;
   logic          in_valid, in_ready;
   logic [7:0]    out_data;
   logic          out_valid, out_ready;
   logic [CW-1:0] tmo_c, addr_c, ovf_c;
   logic          frame_drop;

   int            vectors = 0;
   int            miscompares = 0;
   int            drop_seen = 0;
   logic [7:0]    exp_q [$];
   logic [7:0]    mon_exp;

   always #5 clk = ~clk;

   rx_frame_guard #(.DEPTH(DEPTH), .TIMEOUT_CYC(TMO), .N_SRC(NSRC), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .err_tmo_cnt(tmo_c), .err_addr_cnt(addr_c), .err_ovf_cnt(ovf_c),
      .frame_drop(frame_drop)
   );

   always @(negedge clk) begin
      if (!rst) begin
         if (frame_drop) drop_seen++;
         if (out_valid && out_ready) begin
            vectors++;
            if (exp_q.size() == 0) begin
               miscompares++;
               $display("FAIL out_unexpected: got %02h, expected no output", out_data);
            end else begin
               mon_exp = exp_q.pop_front();
               if (out_data !== mon_exp) begin
                  miscompares++;
                  $display("FAIL out_data: got %02h, expected %02h", out_data, mon_exp);
               end
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic send_byte(input logic [7:0] b);
      in_data  = b;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic send_good(input logic [7:0] b);
      exp_q.push_back(b);
      send_byte(b);
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(posedge clk);
         n++;
      end
      #1;
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: %0d bytes still pending, expected 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      vectors++;
      if (in_ready !== 1'b0) begin
         miscompares++; $display("FAIL reset_in_ready: got %b, expected 0", in_ready);
      end
      vectors++;
      if (out_valid !== 1'b0 || out_data !== 8'h00) begin
         miscompares++;
         $display("FAIL reset_out: got valid=%b data=%02h, expected 0/00", out_valid, out_data);
      end
      vectors++;
      if ({tmo_c, addr_c, ovf_c} !== '0 || frame_drop !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_err: got %0d/%0d/%0d drop=%b, expected 0/0/0 0",
                  tmo_c, addr_c, ovf_c, frame_drop);
      end
      rst = 1'b0;
      @(posedge clk);
      #1;
      vectors++;
      if (in_ready !== 1'b1) begin
         miscompares++; $display("FAIL ready_after_reset: got %b, expected 1", in_ready);
      end
   endtask

   task automatic test_single();
      int d0 = drop_seen;
      out_ready = 1'b1;
      send_good(8'h16); send_good(8'h01); send_good(8'h5A);
      vectors++;
      if (out_valid !== 1'b0) begin
         miscompares++; $display("FAIL latency_early: got out_valid=%b at N+1, expected 0", out_valid);
      end
      @(posedge clk); #1;
      vectors++;
      if (out_valid !== 1'b1 || out_data !== 8'h16) begin
         miscompares++;
         $display("FAIL latency_first: got valid=%b data=%02h at N+2, expected 1/16", out_valid, out_data);
      end
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         vectors++;
         if (out_valid !== 1'b1) begin
            miscompares++; $display("FAIL single_stream: got out_valid=%b at byte %0d, expected 1", out_valid, i + 1);
         end
      end
      drain(20);
      vectors++;
      if ({tmo_c, addr_c, ovf_c} !== '0 || drop_seen != d0) begin
         miscompares++;
         $display("FAIL single_err: got %0d/%0d/%0d drops=%0d, expected 0/0/0 0",
                  tmo_c, addr_c, ovf_c, drop_seen - d0);
      end
   endtask

   task automatic test_timeout();
      int d0 = drop_seen;
      send_byte(8'h08); send_byte(8'h03); send_byte(8'h11); send_byte(8'h22);
      repeat (TMO - 1) @(posedge clk);
      #1;
      vectors++;
      if (tmo_c !== 8'd0) begin
         miscompares++; $display("FAIL tmo_early: got err_tmo_cnt=%0d before timeout, expected 0", tmo_c);
      end
      repeat (6) @(posedge clk);
      #1;
      vectors++;
      if (tmo_c !== 8'd1) begin
         miscompares++; $display("FAIL tmo_cnt: got %0d, expected 1", tmo_c);
      end
      vectors++;
      if (drop_seen - d0 != 1) begin
         miscompares++; $display("FAIL tmo_drop: got %0d pulses, expected 1", drop_seen - d0);
      end
      send_good(8'h16); send_good(8'h00);
      drain(20);
   endtask

   task automatic test_bad_addr();
      int d0 = drop_seen;
      send_byte(8'h19); send_byte(8'h02); send_byte(8'hAA); send_byte(8'hBB);
      repeat (4) @(posedge clk);
      #1;
      vectors++;
      if (addr_c !== 8'd1 || drop_seen - d0 != 1) begin
         miscompares++;
         $display("FAIL bad_addr: got cnt=%0d drops=%0d, expected 1/1", addr_c, drop_seen - d0);
      end
      vectors++;
      if (in_ready !== 1'b1) begin
         miscompares++; $display("FAIL bad_addr_ready: got %b, expected 1", in_ready);
      end
      send_good(8'h18); send_good(8'h00);
      drain(20);
      vectors++;
      if (addr_c !== 8'd1) begin
         miscompares++; $display("FAIL addr_24_ok: got err_addr_cnt=%0d, expected 1", addr_c);
      end
   endtask

   task automatic test_overflow();
      int d0 = drop_seen;
      out_ready = 1'b0;
      for (int f = 0; f < 4; f++) begin
         send_good(8'h16); send_good(8'h02);
         send_good(8'(2 * f + 8'h40)); send_good(8'(2 * f + 8'h41));
      end
      send_byte(8'h16); send_byte(8'h04);
      send_byte(8'hA0); send_byte(8'hA1); send_byte(8'hA2); send_byte(8'hA3);
      repeat (3) @(posedge clk);
      #1;
      vectors++;
      if (ovf_c !== 8'd1 || drop_seen - d0 != 1) begin
         miscompares++;
         $display("FAIL overflow: got cnt=%0d drops=%0d, expected 1/1", ovf_c, drop_seen - d0);
      end
      out_ready = 1'b1;
      drain(60);
      repeat (10) @(posedge clk);
      #1;
      vectors++;
      if (out_valid !== 1'b0) begin
         miscompares++; $display("FAIL overflow_tail: got out_valid=%b after 16 bytes, expected 0", out_valid);
      end
   endtask

   task automatic test_back_to_back();
      int gaps = 0;
      out_ready = 1'b0;
      send_good(8'h16); send_good(8'h00);
      send_good(8'h16); send_good(8'h01); send_good(8'h5A);
      send_good(8'h16); send_good(8'h00);
      repeat (3) @(posedge clk);
      #1;
      out_ready = 1'b1;
      for (int i = 0; i < 7; i++) begin
         if (out_valid !== 1'b1) gaps++;
         @(posedge clk); #1;
      end
      vectors++;
      if (gaps != 0) begin
         miscompares++; $display("FAIL back_to_back: got %0d idle cycles, expected 0", gaps);
      end
      drain(5);
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b1;
      send_byte(8'h08); send_byte(8'h03); send_byte(8'h11);
      rst = 1'b1;
      #1;
      vectors++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== 8'h00) begin
         miscompares++;
         $display("FAIL midreset_io: got ready=%b valid=%b data=%02h, expected 0/0/00",
                  in_ready, out_valid, out_data);
      end
      vectors++;
      if ({tmo_c, addr_c, ovf_c} !== '0 || frame_drop !== 1'b0) begin
         miscompares++;
         $display("FAIL midreset_err: got %0d/%0d/%0d drop=%b, expected 0/0/0 0",
                  tmo_c, addr_c, ovf_c, frame_drop);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      send_good(8'h16); send_good(8'h01); send_good(8'h5A);
      drain(20);
   endtask

   initial begin
      test_reset();
      test_single();
      test_timeout();
      test_bad_addr();
      test_overflow();
      test_back_to_back();
      test_reset_mid();
      repeat (5) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
